sdp_ram_pipe: RTL and testbench

Parametrised simple dual-port RAM with one write port (A) and one read port (B) on a single clock. Adds the following over the first-generation block:
- per-byte write enables
- configurable read pipeline latency with a per-read valid pulse
- defined read-during-write collision mode
- hardware memory-clear sequencer after reset, replacing the per-entry reset loop

Used as the buffer primitive under packet/stream blocks in the same design.

---
 rtl/sdp_ram_pkg.sv | 46 ++++
 rtl/sdp_ram_rd_pipe.sv | 36 +++
 rtl/sdp_ram_pipe.sv | 155 +++++++++++++++
 tb/tb_sdp_ram_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types, limits and word helpers for the simple dual-port RAM.
// Helpers work on MAX_DW-bit containers; callers size-cast in and out.
package sdp_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // Widest word the helpers handle; IW indexes a bit of it.
    localparam int MAX_DW = 256;
    localparam int IW     = $clog2(MAX_DW);

    // Number of byte lanes in a word.
    function automatic int nb_of(input int dw, input int bw);
        return dw / bw;
    endfunction

    // New bits where the owning lane's enable is set, old bits elsewhere.
    function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                     input logic [MAX_DW-1:0] new_w,
                                                     input logic [MAX_DW-1:0] be,
                                                     input int                byte_w);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            r[i[IW-1:0]] = be[IW'(i / byte_w)] ? new_w[i[IW-1:0]] : old_w[i[IW-1:0]];
        end
        return r;
    endfunction

    // Even parity per lane: bit k is the XOR of lane k's bits.
    function automatic logic [MAX_DW-1:0] lane_parity(input logic [MAX_DW-1:0] word,
                                                      input int                byte_w);
        logic [MAX_DW-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            p[IW'(i / byte_w)] = p[IW'(i / byte_w)] ^ word[i[IW-1:0]];
        end
        return p;
    endfunction

endpackage

// File: rtl/sdp_ram_rd_pipe.sv
// sdp_ram_rd_pipe: read-result shift register. Stage 0 captures the word read at
// the accepting edge; stage STAGES drives the port. A data stage only loads behind
// a valid so the tail keeps the last delivered word. Synchronous flush on rst.
module sdp_ram_rd_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic [STAGES:0]        vld_pipe;
    logic [STAGES:0][W-1:0] dat_pipe;

    // Shift valids every cycle; move data only where a valid is moving with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], i_vld};
            if (i_vld) dat_pipe[0] <= i_dat;
            for (int s = 1; s <= STAGES; s++) begin
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign o_vld = vld_pipe[STAGES];
    assign o_dat = dat_pipe[STAGES];

endmodule

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple dual-port RAM, byte-enabled write port A, pipelined read
// port B, collision mode WR_MODE, hardware clear sweep after every reset.
// Optional per-lane even parity with perr output: define SDPRAM_PARITY_EN.
module sdp_ram_pipe
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_W     = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_LATENCY = 2,
    parameter int WR_MODE    = 0,
    localparam int NB        = nb_of(DATA_WIDTH, BYTE_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wena,
    input  logic [NB-1:0]         wbe,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  renb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  dvalb,
    output logic                  init_busy
`ifdef SDPRAM_PARITY_EN
   ,output logic                  perr
`endif
);

    localparam int AI = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
`ifdef SDPRAM_PARITY_EN
    localparam int PW = DATA_WIDTH + 1;
`else
    localparam int PW = DATA_WIDTH;
`endif

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_lat
        $error("sdp_ram_pipe: RD_LATENCY must be within 1..4");
    end
    if (BYTE_W < 1 || (DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_dw
        $error("sdp_ram_pipe: DATA_WIDTH must be a multiple of BYTE_W and at most 256");
    end
    if (MEM_DEPTH < 2 || MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $error("sdp_ram_pipe: MEM_DEPTH must be within 2..2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    fsm_e                  r_state, w_state_nxt;
    logic [AI-1:0]         r_clr_cnt, w_clr_cnt_nxt;
    logic                  w_clr_we;
    logic                  w_run, w_wr, w_rd, w_coll, w_wa_ok, w_ra_ok;
    logic [AI-1:0]         w_wa, w_ra;
    logic [DATA_WIDTH-1:0] w_old_a, w_wdat, w_rd_dat;
    logic [PW-1:0]         w_pipe_in, w_pipe_out;
    logic                  w_pipe_vld;

    // State and clear counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // INIT zeroes one word per cycle and hands over to RUN on the last one.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            INIT: begin
                w_clr_we      = !rst;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == AI'(MEM_DEPTH - 1)) w_state_nxt = RUN;
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    assign init_busy = (r_state == INIT);
    assign w_run     = (r_state == RUN) && !rst;
    assign w_wa_ok   = {1'b0, addra} < DEPTH_W;
    assign w_ra_ok   = {1'b0, addrb} < DEPTH_W;
    assign w_wa      = addra[AI-1:0];
    assign w_ra      = addrb[AI-1:0];
    assign w_wr      = w_run && wena && w_wa_ok;
    assign w_rd      = w_run && renb;
    assign w_coll    = w_wr && (addra == addrb);
    assign w_old_a   = r_mem[w_wa];
    assign w_wdat    = DATA_WIDTH'(byte_merge(MAX_DW'(w_old_a), MAX_DW'(dina),
                                              MAX_DW'(wbe), BYTE_W));

    // Read data: 0 out of range, merged word on a write-first collision.
    always_comb begin
        w_rd_dat = '0;
        if (w_ra_ok) w_rd_dat = (WR_MODE == 1 && w_coll) ? w_wdat : r_mem[w_ra];
    end

`ifdef SDPRAM_PARITY_EN
    logic [NB-1:0] r_par [0:MEM_DEPTH-1];
    logic [NB-1:0] w_pnew, w_pwr, w_rd_par;
    logic          w_perr;

    // Written lanes take fresh parity, others keep what is stored.
    assign w_pnew = NB'(lane_parity(MAX_DW'(dina), BYTE_W));
    assign w_pwr  = (r_par[w_wa] & ~wbe) | (w_pnew & wbe);

    // Stored parity tracks the read data selection.
    always_comb begin
        w_rd_par = '0;
        if (w_ra_ok) w_rd_par = (WR_MODE == 1 && w_coll) ? w_pwr : r_par[w_ra];
    end

    assign w_perr    = |(NB'(lane_parity(MAX_DW'(w_rd_dat), BYTE_W)) ^ w_rd_par);
    assign w_pipe_in = {w_perr, w_rd_dat};

    // Parity array shares the write port with the data array.
    always_ff @(posedge clk) begin
        if (w_clr_we)  r_par[r_clr_cnt] <= '0;
        else if (w_wr) r_par[w_wa]      <= w_pwr;
    end

    assign perr = w_pipe_vld & w_pipe_out[DATA_WIDTH];
`else
    assign w_pipe_in = w_rd_dat;
`endif

    // Single write port: clear sweep in INIT, byte-merged user write in RUN.
    always_ff @(posedge clk) begin
        if (w_clr_we)  r_mem[r_clr_cnt] <= '0;
        else if (w_wr) r_mem[w_wa]      <= w_wdat;
    end

    sdp_ram_rd_pipe #(
        .W      (PW),
        .STAGES (RD_LATENCY)
    ) u_rd_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_rd),
        .i_dat (w_pipe_in),
        .o_vld (w_pipe_vld),
        .o_dat (w_pipe_out)
    );

    assign dvalb = w_pipe_vld;
    assign doutb = w_pipe_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: three RAM configurations on one shared stimulus stream, each
// checked every cycle against a word-level model (array + due-cycle slots).
module tb_sdp_ram_pipe;

    localparam int ND = 3;
    localparam int DEP  [ND] = '{16, 200, 256};
    localparam int LATA [ND] = '{2, 4, 1};
    localparam int MODE [ND] = '{0, 1, 1};

    logic        clk = 1'b0;
    logic        rst, wena, renb;
    logic [3:0]  wbe;
    logic [7:0]  addra, addrb;
    logic [31:0] dina;
    logic [31:0] dout [ND];
    logic        dval [ND];
    logic        busy [ND];
`ifdef SDPRAM_PARITY_EN
    logic        perr [ND];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sdp_ram_pipe #(
            .DATA_WIDTH (32),
            .BYTE_W     (8),
            .ADDR_WIDTH (8),
            .MEM_DEPTH  (DEP[g]),
            .RD_LATENCY (LATA[g]),
            .WR_MODE    (MODE[g])
        ) u (
            .clk       (clk),
            .rst       (rst),
            .wena      (wena),
            .wbe       (wbe),
            .addra     (addra),
            .dina      (dina),
            .renb      (renb),
            .addrb     (addrb),
            .doutb     (dout[g]),
            .dvalb     (dval[g]),
            .init_busy (busy[g])
`ifdef SDPRAM_PARITY_EN
           ,.perr      (perr[g])
`endif
        );
    end

    // Reference model state.
    logic [31:0] mm   [ND][256];
    logic        cor  [ND][256];
    int          cnt  [ND];
    logic        sv   [ND][8];
    logic [31:0] sd   [ND][8];
    logic        sp   [ND][8];
    logic        ev   [ND];
    logic        ep   [ND];
    logic [31:0] last [ND];
    int          edge_no = 0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
        logic [31:0] m;
        m = o;
        for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = n[8*l +: 8];
        return m;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut%0d cyc%0d: got %h want %h", tag, k, edge_no, o, e);
        end
    endtask

    // Apply one clock edge of the spec rules to every model instance.
    task automatic model_edge();
        int          s;
        logic [31:0] v;
        logic        p;
        logic        coll;
        edge_no++;
        s = edge_no % 8;
        for (int k = 0; k < ND; k++) begin
            ev[k] = 1'b0;
            ep[k] = 1'b0;
            if (rst) begin
                cnt[k]  = 0;
                last[k] = '0;
                for (int i = 0; i < 8; i++) sv[k][i] = 1'b0;
                for (int a = 0; a < 256; a++) begin
                    mm[k][a]  = '0;
                    cor[k][a] = 1'b0;
                end
            end else if (cnt[k] < DEP[k]) begin
                cnt[k]++;
            end else begin
                if (sv[k][s]) begin
                    ev[k]   = 1'b1;
                    ep[k]   = sp[k][s];
                    last[k] = sd[k][s];
                    sv[k][s] = 1'b0;
                end
                coll = wena && (addra == addrb) && (int'(addra) < DEP[k]);
                if (renb) begin
                    v = '0;
                    p = 1'b0;
                    if (int'(addrb) < DEP[k]) begin
                        v = mm[k][addrb];
                        p = cor[k][addrb];
                        if (MODE[k] == 1 && coll) begin
                            v = mrg(v, dina, wbe);
                            if (wbe[0]) p = 1'b0;
                        end
                    end
                    sv[k][(edge_no + LATA[k]) % 8] = 1'b1;
                    sd[k][(edge_no + LATA[k]) % 8] = v;
                    sp[k][(edge_no + LATA[k]) % 8] = p;
                end
                if (wena && int'(addra) < DEP[k]) begin
                    mm[k][addra] = mrg(mm[k][addra], dina, wbe);
                    if (wbe[0]) cor[k][addra] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < ND; k++) begin
            chk("init_busy", k, {31'b0, busy[k]}, {31'b0, (cnt[k] < DEP[k])});
            chk("dvalb", k, {31'b0, dval[k]}, {31'b0, ev[k]});
            chk("doutb", k, dout[k], last[k]);
`ifdef SDPRAM_PARITY_EN
            chk("perr", k, {31'b0, perr[k]}, {31'b0, ev[k] & ep[k]});
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        wena = 1'b0;
        renb = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wena = 1'b1; renb = 1'b0; addra = a; dina = d; wbe = be;
        tick();
    endtask

    task automatic rd(input logic [7:0] a);
        wena = 1'b0; renb = 1'b1; addrb = a;
        tick();
    endtask

    initial begin
        for (int k = 0; k < ND; k++) begin
            cnt[k] = 0; last[k] = '0; ev[k] = 1'b0; ep[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin sv[k][i] = 1'b0; sd[k][i] = '0; sp[k][i] = 1'b0; end
            for (int a = 0; a < 256; a++) begin mm[k][a] = '0; cor[k][a] = 1'b0; end
        end
        rst = 1'b1; wena = 1'b0; renb = 1'b0; wbe = '0;
        addra = '0; addrb = '0; dina = '0;
        repeat (3) tick();

        // Clear sweep with a write held on the port during INIT.
        rst = 1'b0;
        wena = 1'b1; wbe = 4'hF; addra = 8'd3; dina = 32'hFFFF_FFFF;
        repeat (16) tick();
        idle();
        rd(8'd3);
        idle();
        repeat (4) tick();
        chk("clr_read3", 0, dout[0], 32'h0);
        repeat (240) tick();

        // Byte-enable merge and latency.
        wr(8'd5, 32'h1122_3344, 4'hF);
        wr(8'd5, 32'hAABB_CCDD, 4'h5);
        rd(8'd5);
        idle();
        repeat (5) tick();
        for (int k = 0; k < ND; k++) chk("bytelane", k, dout[k], 32'h11BB_33DD);

        // Back-to-back reads.
        for (int a = 0; a < 8; a++) wr(8'(a), 32'(a), 4'hF);
        for (int a = 0; a < 8; a++) rd(8'(a));
        idle();
        repeat (6) tick();
        for (int k = 0; k < ND; k++) chk("b2b_last", k, dout[k], 32'h7);

        // Collision on an untouched word.
        wena = 1'b1; wbe = 4'h3; addra = 8'd9; dina = 32'h1234_5678;
        renb = 1'b1; addrb = 8'd9;
        tick();
        idle();
        repeat (6) tick();
        chk("coll_rf", 0, dout[0], 32'h0);
        chk("coll_wf", 1, dout[1], 32'h0000_5678);
        chk("coll_wf", 2, dout[2], 32'h0000_5678);
        rd(8'd9);
        idle();
        repeat (6) tick();
        for (int k = 0; k < ND; k++) chk("coll_store", k, dout[k], 32'h0000_5678);

        // Out-of-range write then read (in range only for the 256-deep instance).
        wr(8'd250, 32'hDEAD_BEEF, 4'hF);
        rd(8'd250);
        idle();
        repeat (6) tick();
        chk("oor", 0, dout[0], 32'h0);
        chk("oor", 1, dout[1], 32'h0);
        chk("inr", 2, dout[2], 32'hDEAD_BEEF);

`ifdef SDPRAM_PARITY_EN
        // Corrupt one stored bit, read it back, then heal it with a full write.
        g_dut[0].u.r_mem[5] = g_dut[0].u.r_mem[5] ^ 32'h1;
        mm[0][5]  = mm[0][5] ^ 32'h1;
        cor[0][5] = 1'b1;
        rd(8'd5);
        idle();
        repeat (6) tick();
        wr(8'd5, 32'h5, 4'hF);
        idle();
        tick();
`endif

        // Random traffic with frequent collisions and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            wena  = 1'($urandom_range(0, 1));
            renb  = 1'($urandom_range(0, 1));
            wbe   = 4'($urandom);
            dina  = $urandom;
            addra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
            addrb = ($urandom_range(0, 3) == 0) ? addra
                  : (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19)));
            tick();
        end
        idle();
        repeat (6) tick();

        // Reset with reads in flight, then a fresh sweep.
        for (int i = 0; i < 3; i++) rd(8'(i + 5));
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < ND; k++) chk("rst_dout", k, dout[k], 32'h0);
        repeat (258) tick();
        wr(8'd4, 32'hCAFE_0004, 4'hF);
        rd(8'd4);
        idle();
        repeat (6) tick();
        for (int k = 0; k < ND; k++) chk("post_rst", k, dout[k], 32'hCAFE_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
